instr_prefetch_queue: RTL and testbench

Fetch stage that sits directly upstream of the instruction register. It reads 16-bit instructions from byte-wide instruction memory, little-endian, as two byte reads per word (low byte at addr, high byte at addr+1). Fetched words, each tagged with its fetch address, go into a small FIFO. The FIFO feeds the control/IR stage through a valid/ready handshake. A jump redirect flushes the queue and restarts fetch at a new address.

---
 rtl/instr_prefetch_queue.sv | 184 ++++++++++++++++++
 tb/tb_instr_prefetch_queue.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_queue.sv
// ---------------------------------------------------------------------------
// instr_prefetch_queue
//
// Purpose:
//   Fetch stage in front of the instruction register. It assembles 16-bit
//   little-endian instructions from a byte-wide instruction memory (low byte
//   at fetch_pc, high byte at fetch_pc+1) and stores them in a small FIFO.
//   Each entry is tagged with its fetch address. The consumer drains the FIFO
//   through a valid/ready handshake. A redirect flushes the FIFO and restarts
//   fetching at a new address.
//
// Ports:
//   clk           - clock, all state changes on the rising edge
//   reset         - synchronous active-low reset
//   mem_rd_en     - byte read strobe to instruction memory
//   mem_addr      - byte address of the current read
//   mem_rd_data   - read data, valid one cycle after mem_rd_en
//   instr_valid   - queue head holds a valid instruction
//   instr_ready   - consumer accepts the head this cycle
//   instr         - head instruction word {hi,lo}
//   instr_pc      - byte address of the head instruction
//   redirect      - jump taken: flush and refetch
//   redirect_addr - new fetch address (odd values allowed)
//   halt          - blocks new word fetches while high
//   queue_count   - number of words held, 0..DEPTH
// ---------------------------------------------------------------------------
module instr_prefetch_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    output logic             mem_rd_en,
    output logic [15:0]      mem_addr,
    input  logic [7:0]       mem_rd_data,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [15:0]      instr,
    output logic [15:0]      instr_pc,
    input  logic             redirect,
    input  logic [15:0]      redirect_addr,
    input  logic             halt,
    output logic [CNT_W-1:0] queue_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] ST_FETCH_LO = 2'd0;
    localparam logic [1:0] ST_FETCH_HI = 2'd1;
    localparam logic [1:0] ST_WRITE    = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [15:0]      fetch_pc_q, fetch_pc_d;
    logic [7:0]       lo_byte_q, lo_byte_d;
    logic [15:0]      word_q [DEPTH];
    logic [15:0]      word_d [DEPTH];
    logic [15:0]      tag_q  [DEPTH];
    logic [15:0]      tag_d  [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic issue;
    logic push;
    logic pop;

    // A new word is only started when there is room for it; since only one
    // word is ever in flight and the count can only fall meanwhile, the push
    // in WRITE can never overflow.
    assign issue = (state_q == ST_FETCH_LO) && !halt && (count_q < CNT_W'(DEPTH));

    // Memory interface. Outputs are forced idle while reset is held low so no
    // stray read escapes during reset.
    always_comb begin
        mem_rd_en = 1'b0;
        mem_addr  = fetch_pc_q;
        case (state_q)
            ST_FETCH_LO: mem_rd_en = issue;
            ST_FETCH_HI: begin
                mem_rd_en = 1'b1;
                mem_addr  = fetch_pc_q + 16'd1;
            end
            default: mem_rd_en = 1'b0;
        endcase
        if (!reset) begin
            mem_rd_en = 1'b0;
            mem_addr  = 16'd0;
        end
    end

    // Consumer side: head entry shown directly, zeroed while empty.
    always_comb begin
        instr_valid = (count_q != '0);
        instr       = instr_valid ? word_q[rd_ptr_q] : 16'd0;
        instr_pc    = instr_valid ? tag_q[rd_ptr_q]  : 16'd0;
        queue_count = count_q;
    end

    // Fetch FSM. A redirect wins over everything: the in-flight byte and any
    // pending push are dropped and fetch restarts at redirect_addr.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        lo_byte_d  = lo_byte_q;
        push       = 1'b0;
        case (state_q)
            ST_FETCH_LO: begin
                if (issue) begin
                    state_d = ST_FETCH_HI;
                end
            end
            ST_FETCH_HI: begin
                lo_byte_d = mem_rd_data;
                state_d   = ST_WRITE;
            end
            ST_WRITE: begin
                push       = 1'b1;
                fetch_pc_d = fetch_pc_q + 16'd2;
                state_d    = ST_FETCH_LO;
            end
            default: state_d = ST_FETCH_LO;
        endcase
        pop = instr_valid && instr_ready;
        if (redirect) begin
            state_d    = ST_FETCH_LO;
            fetch_pc_d = redirect_addr;
            push       = 1'b0;
            pop        = 1'b0;
        end
    end

    // FIFO bookkeeping; full and empty are told apart by the count.
    always_comb begin
        word_d   = word_q;
        tag_d    = tag_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                word_d[wr_ptr_q] = {mem_rd_data, lo_byte_q};
                tag_d[wr_ptr_q]  = fetch_pc_q;
                wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_FETCH_LO;
            fetch_pc_q <= 16'd0;
            lo_byte_q  <= 8'd0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= 16'd0;
                tag_q[i]  <= 16'd0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            lo_byte_q  <= lo_byte_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            word_q     <= word_d;
            tag_q      <= tag_d;
        end
    end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// ---------------------------------------------------------------------------
// tb_instr_prefetch_queue
//
// Purpose:
//   Directed self-checking bench for instr_prefetch_queue. A 64 KiB byte
//   memory model answers reads one cycle after mem_rd_en; expected words are
//   built from that model's own contents.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_instr_prefetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rd_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic        halt;
    logic [2:0]  queue_count;

    logic [7:0]  mem [0:65535];

    int n_checks = 0;
    int n_errors = 0;

    instr_prefetch_queue #(.DEPTH(4), .CNT_W(3)) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_rd_en     (mem_rd_en),
        .mem_addr      (mem_addr),
        .mem_rd_data   (mem_rd_data),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .halt          (halt),
        .queue_count   (queue_count)
    );

    always #5 clk = ~clk;

    // Byte memory with one cycle of read latency.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rd_data <= mem[mem_addr];
        end
    end

    function automatic logic [15:0] exp_word(input logic [15:0] pc);
        logic [15:0] pc1;
        pc1 = pc + 16'd1;
        return {mem[pc1], mem[pc]};
    endfunction

    task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step until the head is valid (at least one step), bounded.
    task automatic wait_valid(input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (instr_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check_output({tag, "_timeout"}, 16'd0, 16'd1);
        end
    endtask

    initial begin
        bit ok;
        int bad;

        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'((i * 37) + 11);
        end
        mem[0] = 8'h34; mem[1] = 8'h12; mem[2] = 8'hCD; mem[3] = 8'hAB;
        mem[16'hFFFE] = 8'h11; mem[16'hFFFF] = 8'h22;

        reset = 1'b0; instr_ready = 1'b0; halt = 1'b0;
        redirect = 1'b0; redirect_addr = 16'd0;

        // Reset state
        repeat (3) step();
        check_output("rst_count", 16'(queue_count), 16'd0);
        check_output("rst_valid", 16'(instr_valid), 16'd0);
        check_output("rst_rd_en", 16'(mem_rd_en), 16'd0);
        check_output("rst_addr", mem_addr, 16'd0);
        check_output("rst_instr", instr, 16'd0);
        check_output("rst_pc", instr_pc, 16'd0);

        // Cold start, consumer always ready
        instr_ready = 1'b1;
        reset = 1'b1;
        #1;
        check_output("cold_c0_rd_en", 16'(mem_rd_en), 16'd1);
        check_output("cold_c0_addr", mem_addr, 16'h0000);
        step();
        check_output("cold_c1_addr", mem_addr, 16'h0001);
        check_output("cold_c1_valid", 16'(instr_valid), 16'd0);
        step();
        check_output("cold_c2_rd_en", 16'(mem_rd_en), 16'd0);
        check_output("cold_c2_valid", 16'(instr_valid), 16'd0);
        step();
        check_output("cold_c3_valid", 16'(instr_valid), 16'd1);
        check_output("cold_c3_instr", instr, 16'h1234);
        check_output("cold_c3_pc", instr_pc, 16'h0000);
        step();
        check_output("cold_c4_valid", 16'(instr_valid), 16'd0);
        step();
        step();
        check_output("cold_c6_instr", instr, 16'hABCD);
        check_output("cold_c6_pc", instr_pc, 16'h0002);

        // Backpressure from a fresh reset
        reset = 1'b0;
        instr_ready = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (queue_count == 3'd4 && mem_rd_en) bad++;
        end
        check_output("bp_count_full", 16'(queue_count), 16'd4);
        check_output("bp_no_read_when_full", 16'(bad), 16'd0);
        check_output("bp_head_pc", instr_pc, 16'h0000);
        check_output("bp_head_instr", instr, 16'h1234);
        instr_ready = 1'b1;
        step();
        check_output("drain_pc2", instr_pc, 16'h0002);
        check_output("drain_instr2", instr, 16'hABCD);
        check_output("drain_resume_rd_en", 16'(mem_rd_en), 16'd1);
        check_output("drain_resume_addr", mem_addr, 16'h0008);
        step();
        check_output("drain_pc4", instr_pc, 16'h0004);
        check_output("drain_instr4", instr, exp_word(16'h0004));
        step();
        check_output("drain_pc6", instr_pc, 16'h0006);
        check_output("drain_instr6", instr, exp_word(16'h0006));
        step();
        check_output("drain_pc8", instr_pc, 16'h0008);
        check_output("drain_instr8", instr, exp_word(16'h0008));
        check_output("drain_count_pushpop", 16'(queue_count), 16'd1);

        // Redirect during a FETCH_HI cycle
        step();
        check_output("redir_in_hi_addr", mem_addr, 16'h000B);
        redirect = 1'b1; redirect_addr = 16'h0100;
        step();
        redirect = 1'b0;
        #1;
        check_output("redir_valid", 16'(instr_valid), 16'd0);
        check_output("redir_count", 16'(queue_count), 16'd0);
        check_output("redir_first_addr", mem_addr, 16'h0100);
        wait_valid("redir_wait", ok);
        check_output("redir_first_pc", instr_pc, 16'h0100);
        check_output("redir_first_instr", instr, exp_word(16'h0100));

        // Wrap-around at 0xFFFE
        mem[0] = 8'h33; mem[1] = 8'h44;
        redirect = 1'b1; redirect_addr = 16'hFFFE;
        step();
        redirect = 1'b0;
        wait_valid("wrap_a_wait", ok);
        check_output("wrap_a_pc", instr_pc, 16'hFFFE);
        check_output("wrap_a_instr", instr, 16'h2211);
        wait_valid("wrap_b_wait", ok);
        check_output("wrap_b_pc", instr_pc, 16'h0000);
        check_output("wrap_b_instr", instr, 16'h4433);

        // Odd redirect at 0xFFFF: high byte comes from 0x0000
        redirect = 1'b1; redirect_addr = 16'hFFFF;
        step();
        redirect = 1'b0;
        #1;
        check_output("odd_lo_rd_en", 16'(mem_rd_en), 16'd1);
        check_output("odd_lo_addr", mem_addr, 16'hFFFF);
        step();
        check_output("odd_hi_rd_en", 16'(mem_rd_en), 16'd1);
        check_output("odd_hi_addr", mem_addr, 16'h0000);
        wait_valid("odd_a_wait", ok);
        check_output("odd_a_pc", instr_pc, 16'hFFFF);
        check_output("odd_a_instr", instr, 16'h3322);
        wait_valid("odd_b_wait", ok);
        check_output("odd_b_pc", instr_pc, 16'h0001);
        check_output("odd_b_instr", instr, 16'hCD44);

        // Halt raised during FETCH_HI of the word at 0x0003
        step();
        halt = 1'b1;
        #1;
        check_output("halt_hi_rd_en", 16'(mem_rd_en), 16'd1);
        check_output("halt_hi_addr", mem_addr, 16'h0004);
        step();
        check_output("halt_write_rd_en", 16'(mem_rd_en), 16'd0);
        step();
        check_output("halt_pushed_valid", 16'(instr_valid), 16'd1);
        check_output("halt_pushed_pc", instr_pc, 16'h0003);
        check_output("halt_pushed_instr", instr, exp_word(16'h0003));
        check_output("halt_lo_rd_en", 16'(mem_rd_en), 16'd0);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (mem_rd_en) bad++;
        end
        check_output("halt_no_reads", 16'(bad), 16'd0);
        check_output("halt_drained", 16'(queue_count), 16'd0);
        instr_ready = 1'b0;
        halt = 1'b0;
        #1;
        check_output("unhalt_rd_en", 16'(mem_rd_en), 16'd1);
        check_output("unhalt_addr", mem_addr, 16'h0005);

        // Reset with three queued words and a read in flight
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (queue_count == 3'd3) begin
                ok = 1'b1;
                break;
            end
        end
        check_output("fill3_reached", 16'(ok), 16'd1);
        step();
        check_output("inflight_addr", mem_addr, 16'h000C);
        reset = 1'b0;
        step();
        check_output("midrst_count", 16'(queue_count), 16'd0);
        check_output("midrst_valid", 16'(instr_valid), 16'd0);
        check_output("midrst_rd_en", 16'(mem_rd_en), 16'd0);
        check_output("midrst_instr", instr, 16'd0);
        reset = 1'b1;
        instr_ready = 1'b1;
        #1;
        check_output("postrst_rd_en", 16'(mem_rd_en), 16'd1);
        check_output("postrst_addr", mem_addr, 16'h0000);
        wait_valid("postrst_wait", ok);
        check_output("postrst_pc", instr_pc, 16'h0000);
        check_output("postrst_instr", instr, 16'h4433);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
